datapath_rr_arbiter: RTL

DATAPATH_RR_ARBITER -- requirements
Module: datapath_rr_arbiter

---
 rtl/datapath_arb_pkg.sv | 17 +
 rtl/rr_priority_picker.sv | 52 +++++
 rtl/datapath_rr_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/datapath_arb_pkg.sv
// Shared definitions for the round-robin datapath arbiter.
// Holds the arbiter FSM state encoding, the default sizing parameters
// and the width of a grant index at the default requester count.
package datapath_arb_pkg;

    localparam int NUM_REQ_DEF       = 4;
    localparam int DATA_W_DEF        = 16;
    localparam int WARMUP_CYCLES_DEF = 4;
    localparam int GRANT_W           = $clog2(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        ARB    = 2'd1,
        HOLD   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin priority picker.
// Searches the request vector cyclically, starting at rr_ptr, and returns
// the first set bit as a one-hot grant plus its binary index.
// Ports:
//   req         in   NUM_REQ  request vector
//   rr_ptr      in   IDX_W    index where the search starts
//   grant       out  NUM_REQ  one-hot grant (all zero if no request)
//   grant_idx   out  IDX_W    index of the granted bit
//   grant_valid out  1        at least one request was found
module rr_priority_picker
    import datapath_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = GRANT_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;
    logic             hit_s;
    logic             found_s;

    // Cyclic first-set search: candidate index wraps modulo NUM_REQ so any requester count works
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        sum_s     = '0;
        cand_s    = '0;
        hit_s     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (sum_s >= (IDX_W+1)'(NUM_REQ)) begin
                cand_s = IDX_W'(sum_s - (IDX_W+1)'(NUM_REQ));
            end else begin
                cand_s = sum_s[IDX_W-1:0];
            end
            hit_s          = ~found_s & req[cand_s];
            grant[cand_s]  = grant[cand_s] | hit_s;
            grant_idx      = hit_s ? cand_s : grant_idx;
            found_s        = found_s | hit_s;
        end
    end

    assign grant_valid = found_s;

endmodule

// File: rtl/datapath_rr_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ requester words into one
// registered output word. After reset it idles WARMUP_CYCLES cycles, then
// accepts one word at a time (ARB), holds it until downstream takes it
// (HOLD), and advances the round-robin pointer past the served requester.
// Ports:
//   clk         in   1               rising-edge clock
//   sync_rst    in   1               synchronous active-high reset
//   req_valid   in   NUM_REQ         per-requester word available
//   req_data    in   NUM_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W]
//   req_ready   out  NUM_REQ         one-hot accept strobe (combinational)
//   out_data    out  DATA_W          registered word toward the datapath
//   out_valid   out  1               out_data valid
//   out_ready   in   1               downstream accepts out_data
//   grant_id    out  clog2(NUM_REQ)  source of the current out_data
//   xfer_count  out  16              completed transfers since reset
module datapath_rr_arbiter
    import datapath_arb_pkg::*;
#(
    parameter int NUM_REQ       = NUM_REQ_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int WARMUP_CYCLES = WARMUP_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       sync_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [15:0]                xfer_count
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int WCNT_W = $clog2(WARMUP_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

    arb_state_e         state_r;
    arb_state_e         state_nxt_s;
    logic [WCNT_W-1:0]  wcnt_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [DATA_W-1:0]  out_data_r;
    logic               out_valid_r;
    logic [IDX_W-1:0]   grant_id_r;
    logic [15:0]        xfer_cnt_r;

    logic [NUM_REQ-1:0] pick_grant_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_valid_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic               accept_s;
    logic               release_s;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req         (req_valid),
        .rr_ptr      (rr_ptr_r),
        .grant       (pick_grant_s),
        .grant_idx   (pick_idx_s),
        .grant_valid (pick_valid_s)
    );

    // One-hot AND-OR mux of the granted requester's word
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data_s = sel_data_s | ({DATA_W{pick_grant_s[i]}} & req_data[i*DATA_W +: DATA_W]);
        end
    end

    // Next-state decode and handshake strobes; req_ready is masked while reset is asserted
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        release_s   = 1'b0;
        req_ready   = '0;
        case (state_r)
            WARMUP: begin
                if (wcnt_r == WARM_LAST) begin
                    state_nxt_s = ARB;
                end else begin
                    state_nxt_s = WARMUP;
                end
            end
            ARB: begin
                if (pick_valid_s && !sync_rst) begin
                    accept_s    = 1'b1;
                    req_ready   = pick_grant_s;
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = ARB;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    release_s   = 1'b1;
                    state_nxt_s = ARB;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = WARMUP;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_r <= WARMUP;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Warm-up counter, output register, round-robin pointer and transfer counter
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wcnt_r      <= '0;
            rr_ptr_r    <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            grant_id_r  <= '0;
            xfer_cnt_r  <= 16'd0;
        end else begin
            if (state_r == WARMUP && wcnt_r != WARM_LAST) begin
                wcnt_r <= wcnt_r + WCNT_W'(1);
            end
            if (accept_s) begin
                out_data_r  <= sel_data_s;
                grant_id_r  <= pick_idx_s;
                out_valid_r <= 1'b1;
            end else if (release_s) begin
                out_valid_r <= 1'b0;
                rr_ptr_r    <= (grant_id_r == IDX_LAST) ? '0 : grant_id_r + IDX_W'(1);
                xfer_cnt_r  <= xfer_cnt_r + 16'd1;
            end
        end
    end

    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign grant_id   = grant_id_r;
    assign xfer_count = xfer_cnt_r;

endmodule
